// File: rtl/sram_100_qsys_cpu_oci_dct_packer.sv
// sram_100_qsys_cpu_oci_dct_packer
//   Packs a stream of 2-bit trace symbols (up to four per beat) into 30-bit
//   capture words of SLOTS slots. Each word goes to the trace sink over a
//   valid/ready handshake. The block also sequences the end-of-test drain:
//   on test_ending it flushes any partial word, then raises test_has_ended.
//
//   Optional feature macro: SRAM_100_DCT_STATS_EN
//     defined   -> dct_words counts completed output transfers (saturating).
//     undefined -> dct_words is tied to zero and no counter is built.
module sram_100_qsys_cpu_oci_dct_packer #(
   parameter int SLOTS  = 15,
   parameter int STAT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           sym_data,
   input  logic [2:0]           sym_count,
   input  logic                 sym_valid,
   output logic                 sym_ready,
   input  logic                 test_ending,
   output logic [2*SLOTS-1:0]   dct_buffer,
   output logic [3:0]           dct_count,
   output logic                 dct_valid,
   input  logic                 dct_ready,
   output logic                 test_has_ended,
   output logic [STAT_W-1:0]    dct_words
);

   localparam int         AW   = 2 * SLOTS;  // accumulator width in bits
   localparam int         EW   = AW + 6;     // room for up to three overflow symbols
   localparam logic [4:0] FULL = 5'(SLOTS);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_ENDED
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [3:0]      acc_cnt_q, acc_cnt_d;
   logic [AW-1:0]   buf_d;
   logic [3:0]      cnt_d;
   logic            valid_d;

   logic [2:0]      n_eff;    // sym_count clamped to 0..4
   logic [4:0]      total;    // acc_cnt + n_eff, up to 18
   logic [7:0]      sym_masked;
   logic [EW-1:0]   merged;   // accumulator with the new beat written in order
   logic            ofree;
   logic            accept;

   // Next-state, packing and handshake decisions for the whole datapath.
   // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      acc_cnt_d  = acc_cnt_q;
      buf_d      = dct_buffer;
      cnt_d      = dct_count;
      valid_d    = dct_valid & ~dct_ready;
      sym_ready  = 1'b0;
      accept     = 1'b0;
      sym_masked = '0;

      n_eff = (sym_count > 3'd4) ? 3'd4 : sym_count;
      ofree = ~dct_valid | dct_ready;
      total = {1'b0, acc_cnt_q} + {2'b00, n_eff};

      // Symbols beyond the valid count are dropped so unused slots stay zero.
      for (int i = 0; i < 4; i++) begin
         if (i < int'(n_eff)) sym_masked[2*i +: 2] = sym_data[2*i +: 2];
      end
      merged = {6'b0, acc_q} | ({{(EW-8){1'b0}}, sym_masked} << {acc_cnt_q, 1'b0});

      unique case (state_q)
         ST_RUN: begin
            // A completing beat needs the output register; a partial one does not.
            sym_ready = ofree | (total < FULL);
            accept    = sym_valid & sym_ready;
            if (accept && (n_eff != 3'd0)) begin
               if (total >= FULL) begin
                  buf_d     = merged[AW-1:0];
                  cnt_d     = 4'(SLOTS);
                  valid_d   = 1'b1;
                  acc_d     = {{(AW-6){1'b0}}, merged[EW-1:AW]};
                  acc_cnt_d = 4'(total - FULL);
               end else begin
                  acc_d     = merged[AW-1:0];
                  acc_cnt_d = total[3:0];
               end
            end
            if (test_ending) begin
               state_d = ((acc_cnt_d == 4'd0) && !valid_d) ? ST_ENDED : ST_FLUSH;
            end
         end

         ST_FLUSH: begin
            if (ofree && (acc_cnt_q != 4'd0)) begin
               buf_d     = acc_q;
               cnt_d     = acc_cnt_q;
               valid_d   = 1'b1;
               acc_d     = '0;
               acc_cnt_d = 4'd0;
            end
            if ((acc_cnt_d == 4'd0) && !valid_d) state_d = ST_ENDED;
         end

         ST_ENDED: begin
            acc_d     = '0;
            acc_cnt_d = 4'd0;
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State, accumulator and output word registers.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         acc_q      <= '0;
         acc_cnt_q  <= 4'd0;
         dct_buffer <= '0;
         dct_count  <= 4'd0;
         dct_valid  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         acc_cnt_q  <= acc_cnt_d;
         dct_buffer <= buf_d;
         dct_count  <= cnt_d;
         dct_valid  <= valid_d;
      end
   end

   assign test_has_ended = (state_q == ST_ENDED);

`ifdef SRAM_100_DCT_STATS_EN
   logic [STAT_W-1:0] words_q;

   // Saturating count of words accepted by the sink.
   always_ff @(posedge clk) begin
      if (reset) begin
         words_q <= '0;
      end else if (dct_valid && dct_ready && (words_q != {STAT_W{1'b1}})) begin
         words_q <= words_q + 1'b1;
      end
   end

   assign dct_words = words_q;
`else
   assign dct_words = '0;
`endif

endmodule
